trace_capture_unit: RTL and testbench

Synthesizable per-cycle execution trace capture for the single-cycle MIPS core: a parametrised circular trace buffer with PC-match trigger, post-trigger window, freeze and valid/ready dump stream, plus saturating instruction-class counters. It sits beside the core, tapping the program counter, fetched instruction and ALU result/zero, and replaces simulation-only `$display` tracing with hardware that also works on the board.

---
 rtl/trace_capture_unit_if.sv | 37 +++
 rtl/trace_capture_unit.sv | 198 +++++++++++++++++++
 tb/tb_trace_capture_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_unit_if.sv
// trace_capture_unit_if
//   Dump stream between the trace capture unit (master) and a consumer
//   (slave). Carries one trace entry per transfer.
//
//   out_valid  master -> slave  entry fields below are meaningful
//   out_ready  slave  -> master consumer accepts the presented entry
//   out_pc     master -> slave  captured program counter
//   out_instr  master -> slave  captured instruction word
//   out_alu    master -> slave  captured ALU result
//   out_zero   master -> slave  captured ALU zero flag
//   out_last   master -> slave  presented entry is the final one of the dump
//
//   Handshake: a transfer happens on a rising edge where out_valid and
//   out_ready are both high. Once out_valid is raised, the master keeps it
//   and every out_* field stable until that transfer; out_ready may change
//   freely and never gates out_valid.
interface trace_capture_unit_if #(
    parameter int XLEN = 32
) ();
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_alu;
    logic            out_zero;
    logic            out_last;

    modport master (
        output out_valid, out_pc, out_instr, out_alu, out_zero, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_instr, out_alu, out_zero, out_last,
        output out_ready
    );
endinterface

// File: rtl/trace_capture_unit.sv
// trace_capture_unit
//   Per-cycle execution trace capture for the single-cycle MIPS core.
//   A circular buffer records {pc, instr, alu_res, alu_zero} for every
//   retired instruction until a PC-match trigger plus a post-trigger window
//   freezes it; the frozen contents are then streamed oldest-first over the
//   dump interface. Saturating counters classify every captured instruction.
//
//   clk, reset        core clock, synchronous active-high reset
//   cap_valid         current cycle retires an instruction
//   pc/instr/alu_res/alu_zero   tapped core signals
//   trig_en/trig_pc   PC-match trigger enable and address
//   dump_start        one-cycle dump request (honoured only while frozen)
//   clr_cnt           clear all class counters
//   dump              dump stream (master side)
//   frozen            buffer frozen (FROZEN or DUMP)
//   cnt_*             instruction-class counters
//   dbg_state         FSM state: 0 ARMED, 1 POST, 2 FROZEN, 3 DUMP
//   dbg_fill          number of valid entries in the buffer
//   dbg_wr_ptr        next write slot
module trace_capture_unit #(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 32,
    parameter int POST_TRIG = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_valid,
    input  logic [XLEN-1:0]          pc,
    input  logic [XLEN-1:0]          instr,
    input  logic [XLEN-1:0]          alu_res,
    input  logic                     alu_zero,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     dump_start,
    input  logic                     clr_cnt,
    trace_capture_unit_if.master     dump,
    output logic                     frozen,
    output logic [CNT_W-1:0]         cnt_r,
    output logic [CNT_W-1:0]         cnt_ld,
    output logic [CNT_W-1:0]         cnt_st,
    output logic [CNT_W-1:0]         cnt_br,
    output logic [CNT_W-1:0]         cnt_j,
    output logic [CNT_W-1:0]         cnt_oth,
    output logic [1:0]               dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_fill,
    output logic [$clog2(DEPTH)-1:0] dbg_wr_ptr
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_POST   = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;
    localparam logic [1:0] ST_DUMP   = 2'd3;

    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

    logic [1:0]      state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_start;
    logic [FW-1:0]   fill;
    logic [FW-1:0]   remaining;
    logic [AW-1:0]   post_cnt;
    logic            capture;
    logic [2:0]      cls;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_alu   [DEPTH];
    logic            mem_zero  [DEPTH];

    logic [CNT_W-1:0] cnt [6];

    // Capture only while the buffer is live; reset suppresses the write too.
    assign capture = cap_valid && !reset && (state == ST_ARMED || state == ST_POST);

    // Oldest entry. When the buffer is full fill[AW-1:0] wraps to 0, so the
    // oldest slot is the one about to be overwritten, i.e. wr_ptr itself.
    assign rd_start = wr_ptr - fill[AW-1:0];

    always_comb begin
        cls = 3'd5;
        case (instr[31:26])
            6'h00:        cls = 3'd0;
            6'h23, 6'h25: cls = 3'd1;
            6'h2B:        cls = 3'd2;
            6'h04, 6'h05: cls = 3'd3;
            6'h02, 6'h03: cls = 3'd4;
            default:      cls = 3'd5;
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= instr;
            mem_alu[wr_ptr]   <= alu_res;
            mem_zero[wr_ptr]  <= alu_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_ARMED;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fill            <= '0;
            remaining       <= '0;
            post_cnt        <= '0;
            dump.out_valid  <= 1'b0;
            dump.out_pc     <= '0;
            dump.out_instr  <= '0;
            dump.out_alu    <= '0;
            dump.out_zero   <= 1'b0;
            dump.out_last   <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != FW'(DEPTH)) fill <= fill + FW'(1);
            end
            case (state)
                ST_ARMED: begin
                    if (capture && trig_en && pc == trig_pc) begin
                        if (POST_TRIG == 0) begin
                            state <= ST_FROZEN;
                        end else begin
                            state    <= ST_POST;
                            post_cnt <= POST_INIT;
                        end
                    end
                end
                ST_POST: begin
                    if (capture) begin
                        post_cnt <= post_cnt - AW'(1);
                        if (post_cnt == AW'(1)) state <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    // Present the oldest entry straight away; rd_ptr then
                    // points at the entry to present after the next transfer.
                    if (dump_start) begin
                        state          <= ST_DUMP;
                        rd_ptr         <= rd_start + AW'(1);
                        remaining      <= fill;
                        dump.out_valid <= 1'b1;
                        dump.out_pc    <= mem_pc[rd_start];
                        dump.out_instr <= mem_instr[rd_start];
                        dump.out_alu   <= mem_alu[rd_start];
                        dump.out_zero  <= mem_zero[rd_start];
                        dump.out_last  <= (fill == FW'(1));
                    end
                end
                default: begin
                    if (dump.out_valid && dump.out_ready) begin
                        if (remaining == FW'(1)) begin
                            state          <= ST_ARMED;
                            fill           <= '0;
                            dump.out_valid <= 1'b0;
                            dump.out_last  <= 1'b0;
                        end else begin
                            rd_ptr         <= rd_ptr + AW'(1);
                            remaining      <= remaining - FW'(1);
                            dump.out_pc    <= mem_pc[rd_ptr];
                            dump.out_instr <= mem_instr[rd_ptr];
                            dump.out_alu   <= mem_alu[rd_ptr];
                            dump.out_zero  <= mem_zero[rd_ptr];
                            dump.out_last  <= (remaining == FW'(2));
                        end
                    end
                end
            endcase
        end
    end

    // clr_cnt wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            for (int k = 0; k < 6; k++) cnt[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < 6; k++) begin
                if (cls == 3'(k) && cnt[k] != {CNT_W{1'b1}}) cnt[k] <= cnt[k] + CNT_W'(1);
            end
        end
    end

    assign cnt_r      = cnt[0];
    assign cnt_ld     = cnt[1];
    assign cnt_st     = cnt[2];
    assign cnt_br     = cnt[3];
    assign cnt_j      = cnt[4];
    assign cnt_oth    = cnt[5];
    assign frozen     = (state == ST_FROZEN) || (state == ST_DUMP);
    assign dbg_state  = state;
    assign dbg_fill   = fill;
    assign dbg_wr_ptr = wr_ptr;
endmodule

// File: tb/tb_trace_capture_unit.sv
module tb_trace_capture_unit;
    localparam int A_DEPTH = 16;
    localparam int A_POST  = 2;
    localparam int A_CMAX  = 65535;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a = 1'b1, reset_b = 1'b1;
    logic        cap_valid = 1'b0, alu_zero = 1'b0, trig_en = 1'b0;
    logic        dump_start = 1'b0, clr_cnt = 1'b0;
    logic [31:0] pc = '0, instr = '0, alu_res = '0, trig_pc = '0;
    logic        ready_a = 1'b1, ready_b = 1'b1;

    logic        frozen_a, frozen_b;
    logic [15:0] cnt_a_r, cnt_a_ld, cnt_a_st, cnt_a_br, cnt_a_j, cnt_a_oth;
    logic [1:0]  cnt_b_r, cnt_b_ld, cnt_b_st, cnt_b_br, cnt_b_j, cnt_b_oth;
    logic [1:0]  state_a, state_b;
    logic [4:0]  fill_a;
    logic [2:0]  fill_b;
    logic [3:0]  wr_a;
    logic [1:0]  wr_b;

    trace_capture_unit_if #(.XLEN(32)) if_a ();
    trace_capture_unit_if #(.XLEN(32)) if_b ();
    assign if_a.out_ready = ready_a;
    assign if_b.out_ready = ready_b;

    trace_capture_unit #(.DEPTH(16), .XLEN(32), .POST_TRIG(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset_a), .cap_valid(cap_valid), .pc(pc), .instr(instr),
        .alu_res(alu_res), .alu_zero(alu_zero), .trig_en(trig_en), .trig_pc(trig_pc),
        .dump_start(dump_start), .clr_cnt(clr_cnt), .dump(if_a), .frozen(frozen_a),
        .cnt_r(cnt_a_r), .cnt_ld(cnt_a_ld), .cnt_st(cnt_a_st), .cnt_br(cnt_a_br),
        .cnt_j(cnt_a_j), .cnt_oth(cnt_a_oth), .dbg_state(state_a), .dbg_fill(fill_a),
        .dbg_wr_ptr(wr_a)
    );

    trace_capture_unit #(.DEPTH(4), .XLEN(32), .POST_TRIG(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .cap_valid(cap_valid), .pc(pc), .instr(instr),
        .alu_res(alu_res), .alu_zero(alu_zero), .trig_en(trig_en), .trig_pc(trig_pc),
        .dump_start(dump_start), .clr_cnt(clr_cnt), .dump(if_b), .frozen(frozen_b),
        .cnt_r(cnt_b_r), .cnt_ld(cnt_b_ld), .cnt_st(cnt_b_st), .cnt_br(cnt_b_br),
        .cnt_j(cnt_b_j), .cnt_oth(cnt_b_oth), .dbg_state(state_b), .dbg_fill(fill_b),
        .dbg_wr_ptr(wr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model of dut_a ----------------
    // The buffer is a queue of the most recent captures (at most DEPTH);
    // a dump copies it and pops one entry per accepted transfer.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic        zero;
    } ent_t;

    ent_t m_q[$];
    ent_t m_dq[$];
    int   m_mode = 0;   // 0 armed, 1 post-window, 2 frozen, 3 dumping
    int   m_left = 0;
    int   m_wr   = 0;   // captures since reset, mod DEPTH
    int   m_cnt[6];

    function automatic int cls_of(input logic [5:0] op);
        if (op == 6'h00) return 0;
        if (op == 6'h23 || op == 6'h25) return 1;
        if (op == 6'h2B) return 2;
        if (op == 6'h04 || op == 6'h05) return 3;
        if (op == 6'h02 || op == 6'h03) return 4;
        return 5;
    endfunction

    task automatic model_edge();
        ent_t e;
        int   mode0;
        logic cap;
        if (reset_a) begin
            m_q.delete(); m_dq.delete();
            m_mode = 0; m_left = 0; m_wr = 0;
            for (int k = 0; k < 6; k++) m_cnt[k] = 0;
            return;
        end
        mode0 = m_mode;
        cap = cap_valid && (mode0 == 0 || mode0 == 1);
        if (clr_cnt) begin
            for (int k = 0; k < 6; k++) m_cnt[k] = 0;
        end else if (cap) begin
            int c;
            c = cls_of(instr[31:26]);
            if (m_cnt[c] < A_CMAX) m_cnt[c]++;
        end
        if (cap) begin
            e.pc = pc; e.instr = instr; e.alu = alu_res; e.zero = alu_zero;
            m_q.push_back(e);
            if (m_q.size() > A_DEPTH) void'(m_q.pop_front());
            m_wr = (m_wr + 1) % A_DEPTH;
            if (mode0 == 0 && trig_en && pc == trig_pc) begin
                if (A_POST == 0) m_mode = 2;
                else begin m_mode = 1; m_left = A_POST; end
            end else if (mode0 == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end
        if (mode0 == 2 && dump_start) begin
            m_dq = m_q;
            m_mode = 3;
        end
        if (mode0 == 3 && ready_a && m_dq.size() > 0) begin
            void'(m_dq.pop_front());
            if (m_dq.size() == 0) begin
                m_mode = 0;
                m_q.delete();
            end
        end
    endtask

    task automatic check_all();
        logic exp_v;
        exp_v = (m_mode == 3);
        chk("valid", if_a.out_valid, exp_v);
        if (exp_v && m_dq.size() > 0) begin
            chk("out_pc", if_a.out_pc, m_dq[0].pc);
            chk("out_instr", if_a.out_instr, m_dq[0].instr);
            chk("out_alu", if_a.out_alu, m_dq[0].alu);
            chk("out_zero", if_a.out_zero, m_dq[0].zero);
            chk("out_last", if_a.out_last, m_dq.size() == 1);
        end
        chk("frozen", frozen_a, m_mode >= 2);
        chk("state", state_a, m_mode);
        chk("fill", fill_a, m_q.size());
        chk("wr_ptr", wr_a, m_wr);
        chk("cnt_r", cnt_a_r, m_cnt[0]);
        chk("cnt_ld", cnt_a_ld, m_cnt[1]);
        chk("cnt_st", cnt_a_st, m_cnt[2]);
        chk("cnt_br", cnt_a_br, m_cnt[3]);
        chk("cnt_j", cnt_a_j, m_cnt[4]);
        chk("cnt_oth", cnt_a_oth, m_cnt[5]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        cap_valid  = 1'b0;
        dump_start = 1'b0;
        clr_cnt    = 1'b0;
    endtask

    task automatic cap(input logic [31:0] p, input logic [31:0] ins);
        cap_valid = 1'b1;
        pc        = p;
        instr     = ins;
        alu_res   = $urandom;
        alu_zero  = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic reset_dut_a();
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
    endtask

    logic [31:0] got_pc[$];
    logic        got_last[$];

    // pat 0: always ready. pat 1: ready 1,0,0,1,... with capture pulses.
    task automatic dump_a(input int pat);
        got_pc.delete();
        got_last.delete();
        ready_a    = 1'b1;
        dump_start = 1'b1;
        step();
        for (int k = 0; k < 100; k++) begin
            if (!if_a.out_valid) break;
            if (pat == 1) begin
                ready_a   = (k % 4 == 0) || (k % 4 == 3);
                cap_valid = 1'b1;
                pc        = 32'h900 + 32'(k * 4);
            end
            if (ready_a) begin
                got_pc.push_back(if_a.out_pc);
                got_last.push_back(if_a.out_last);
            end
            step();
        end
        ready_a = 1'b1;
        chk("dump_done", if_a.out_valid, 1'b0);
    endtask

    task automatic check_dump(input string name, input logic [31:0] first, input int n);
        chk({name, "_count"}, got_pc.size(), n);
        for (int i = 0; i < n && i < got_pc.size(); i++) begin
            chk({name, "_pc"}, got_pc[i], first + 32'(i * 4));
            chk({name, "_last"}, got_last[i], i == n - 1);
        end
    endtask

    typedef struct {
        logic [5:0] op;
        int         cls;
    } vec_t;

    vec_t vecs[8];
    int   tally[6];
    logic [15:0] cnt_now[6];

    initial begin
        vecs[0] = '{6'h00, 0};  // ADD
        vecs[1] = '{6'h23, 1};  // LW
        vecs[2] = '{6'h2B, 2};  // SW
        vecs[3] = '{6'h04, 3};  // BEQ
        vecs[4] = '{6'h02, 4};  // J
        vecs[5] = '{6'h0B, 5};  // SLTIU
        vecs[6] = '{6'h25, 1};  // LHU
        vecs[7] = '{6'h03, 4};  // JAL

        // Reset state
        step();
        reset_dut_a();
        chk("rst_valid", if_a.out_valid, 1'b0);
        chk("rst_frozen", frozen_a, 1'b0);
        chk("rst_fill", fill_a, 0);
        chk("rst_cnt_r", cnt_a_r, 0);

        // Instruction class table
        for (int k = 0; k < 6; k++) tally[k] = 0;
        for (int i = 0; i < 8; i++) begin
            cap(32'h400 + 32'(i * 4), {vecs[i].op, 26'($urandom)});
            tally[vecs[i].cls]++;
            cnt_now = '{cnt_a_r, cnt_a_ld, cnt_a_st, cnt_a_br, cnt_a_j, cnt_a_oth};
            for (int k = 0; k < 6; k++) chk("tbl_cnt", cnt_now[k], tally[k]);
        end
        chk("mix_r", cnt_a_r, 1);
        chk("mix_ld", cnt_a_ld, 2);
        chk("mix_st", cnt_a_st, 1);
        chk("mix_br", cnt_a_br, 1);
        chk("mix_j", cnt_a_j, 2);
        chk("mix_oth", cnt_a_oth, 1);
        clr_cnt = 1'b1;
        cap(32'h500, 32'h0000_0020);
        chk("clr_with_cap", cnt_a_r, 0);

        // Five captures, trigger on 0x08, two post samples
        reset_dut_a();
        trig_en = 1'b1;
        trig_pc = 32'h08;
        for (int i = 0; i < 5; i++) begin
            cap(32'(i * 4), 32'h0000_0020);
            chk("t1_frozen", frozen_a, i == 4);
        end
        dump_a(0);
        check_dump("t1", 32'h0, 5);
        chk("t1_state", state_a, 0);
        chk("t1_fill", fill_a, 0);

        // Wraparound: 20 captures, trigger on pc=0x44
        reset_dut_a();
        trig_pc = 32'h44;
        for (int i = 0; i < 20; i++) cap(32'(i * 4), {6'h23, 26'($urandom)});
        chk("t2_frozen", frozen_a, 1'b1);
        dump_a(0);
        check_dump("t2", 32'h10, 16);

        // Stalled dump with capture pulses during the dump
        reset_dut_a();
        trig_pc = 32'h60C;
        for (int i = 0; i < 6; i++) cap(32'h600 + 32'(i * 4), {6'h2B, 26'($urandom)});
        dump_a(1);
        check_dump("t4", 32'h600, 6);
        chk("t4_fill", fill_a, 0);

        // Reset on the second dump transfer
        reset_dut_a();
        trig_pc = 32'h700;
        for (int i = 0; i < 3; i++) cap(32'h700 + 32'(i * 4), 32'h0);
        dump_start = 1'b1;
        step();
        step();
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        chk("t6_valid", if_a.out_valid, 1'b0);
        chk("t6_state", state_a, 0);
        trig_pc = 32'h200;
        cap(32'h200, 32'h0);
        chk("t6_wr_ptr", wr_a, 1);
        cap(32'h204, 32'h0);
        cap(32'h208, 32'h0);
        dump_a(0);
        check_dump("t6", 32'h200, 3);

        // Second instance: POST_TRIG=0, DEPTH=4, CNT_W=2
        reset_a = 1'b1;
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        chk("b_rst_valid", if_b.out_valid, 1'b0);
        trig_en = 1'b1;
        trig_pc = 32'h100;
        cap(32'h100, {6'h08, 26'h0});
        chk("b_frozen", frozen_b, 1'b1);
        chk("b_state_frozen", state_b, 2);
        chk("b_oth", cnt_b_oth, 1);
        ready_b    = 1'b1;
        dump_start = 1'b1;
        step();
        chk("b_valid", if_b.out_valid, 1'b1);
        chk("b_last", if_b.out_last, 1'b1);
        chk("b_pc", if_b.out_pc, 32'h100);
        step();
        chk("b_valid_end", if_b.out_valid, 1'b0);
        chk("b_state_end", state_b, 0);
        chk("b_fill_end", fill_b, 0);
        trig_en = 1'b0;
        for (int i = 0; i < 5; i++) cap(32'h120 + 32'(i * 4), 32'h0000_0020);
        chk("b_sat", cnt_b_r, 3);
        clr_cnt = 1'b1;
        cap(32'h140, 32'h0000_0020);
        chk("b_clr", cnt_b_r, 0);
        reset_b = 1'b1;

        // Randomized run against the model
        reset_dut_a();
        for (int n = 0; n < 1500; n++) begin
            logic [5:0] ops[10];
            ops = '{6'h00, 6'h00, 6'h23, 6'h25, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h0F};
            reset_a    = ($urandom_range(0, 299) == 0);
            cap_valid  = ($urandom_range(0, 9) < 7);
            pc         = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            instr      = {ops[$urandom_range(0, 9)], 26'($urandom)};
            alu_res    = $urandom;
            alu_zero   = 1'($urandom_range(0, 1));
            trig_en    = 1'($urandom_range(0, 1));
            trig_pc    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            dump_start = ($urandom_range(0, 4) == 0);
            clr_cnt    = ($urandom_range(0, 49) == 0);
            ready_a    = ($urandom_range(0, 9) < 6);
            step();
        end
        reset_a = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
